and2x2_test_sequencer: RTL and testbench
========================================

AND2X2_TEST_SEQUENCER -- requirements
Module: and2x2_test_sequencer

Interface
REQ-001 Parameter SETTLE, default 2, sets the number of wait cycles between driving a vector and sampling Y; legal range 1..15.
REQ-002 CLK  input  1  the single clock; all state changes on the rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 START  input  1  request to begin one full test run; honoured only in IDLE.
REQ-005 Y  input  [0:1]  outputs of the dual 2-input AND device under control.
REQ-006 A  output  [0:1]  A operands driven to the device.
REQ-007 B  output  [0:1]  B operands driven to the device.
REQ-008 BUSY  output  1  high while a run is in progress.
REQ-009 DONE  output  1  one-cycle pulse at the end of a run.
REQ-010 PASS  output  1  result of the last completed run; valid from the DONE cycle until the next START is accepted.
REQ-011 FAIL_IDX  output  [2:0]  index of the first failing vector of the last run; 0 when PASS=1.

Function
REQ-012 FSM states: IDLE, APPLY, WAIT, CHECK, FINISH.
REQ-013 IDLE: START=1 -> APPLY, with vector index cleared to 0, fail flag cleared, and PASS cleared; START=0 -> stay in IDLE.
REQ-014 APPLY: register A/B for the current index; next state is WAIT, with the wait counter loaded to SETTLE.
REQ-015 WAIT: decrement the counter each cycle; move to CHECK when the counter reaches 1, so WAIT lasts exactly SETTLE cycles.
REQ-016 CHECK: compare Y to the expected value for the current index; on the first mismatch, set the fail flag and latch FAIL_IDX; later mismatches do not change FAIL_IDX.
REQ-017 CHECK transitions: index 7 -> FINISH; otherwise increment the index and go to APPLY.
REQ-018 FINISH: assert DONE for one cycle; PASS = NOT fail flag; go to IDLE.
REQ-019 Each vector occupies SETTLE+2 cycles; with START accepted at edge k, DONE is high in cycle k+1+8*(SETTLE+2); for SETTLE=2, that is k+33.
REQ-020 Vector table by index as (A,B):
- 0: (10,10)
- 1: (00,10)
- 2: (10,00)
- 3: (00,00)
- 4: (01,01)
- 5: (00,01)
- 6: (01,00)
- 7: (00,00)
REQ-021 Expected Y is the bitwise AND of A and B, giving Y=10 at index 0, Y=01 at index 4, and Y=00 at every other index.
REQ-022 A and B hold the current vector from APPLY through CHECK, and are 00 in IDLE and FINISH.
REQ-023 BUSY is high in APPLY, WAIT and CHECK only.
REQ-024 START while BUSY is ignored, with no restart and no queuing.
REQ-025 START held high through FINISH is not accepted until the cycle after the return to IDLE.
REQ-026 Y is compared only in CHECK; Y glitches in other states have no effect.

Reset
REQ-027 RST=1 at an edge, in any state, forces the following values, with a mid-run reset aborting the run without a DONE pulse:
- state IDLE, index 0, counter 0, fail flag 0
- A=00, B=00, BUSY=0, DONE=0, PASS=0, FAIL_IDX=0
REQ-028 RST takes priority over START in the same cycle.

Structure
REQ-029 A shared package/include gate_test_pkg holds the FSM state encodings, NUM_VECTORS=8, and the index width of 3.
REQ-030 The vector table and expected values live in one combinational sub-module, gate_vector_rom: input index[2:0], outputs A[0:1], B[0:1] and Y_EXP[0:1].
REQ-031 All FSM, counter and result logic is in and2x2_test_sequencer, and all of its outputs are registered.

Verification
REQ-032 Correct device (MOD_74x08_2 wired A/B->Y), SETTLE=2, START pulse -> DONE at k+33, PASS=1, FAIL_IDX=0.
REQ-033 Y[0] stuck at 0 -> PASS=0, FAIL_IDX=0; Y[1] stuck at 1 -> PASS=0, FAIL_IDX=0 (first mismatch at index 0, Y=11 vs expected 10).
REQ-034 Y[1] stuck at 0 -> PASS=0, FAIL_IDX=4; later indices cause no change.
REQ-035 RST asserted at cycle k+10 of a run -> next cycle BUSY=0, A=B=00, no DONE pulse; a new START then completes normally with PASS=1.
REQ-036 START held high continuously, SETTLE=1 -> DONE every 8*3+2=26 cycles; START pulsed while BUSY -> DONE timing unchanged.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate test sequencer: FSM encoding, vector count and index width.
package gate_test_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int CNT_W       = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/gate_vector_rom.sv
// Combinational vector table for a dual 2-input AND part: operands and expected outputs per index.
module gate_vector_rom
    import gate_test_pkg::*;
(
    input  logic [IDX_W-1:0] index,
    output logic [0:1]       A,
    output logic [0:1]       B,
    output logic [0:1]       Y_EXP
);

    // Each gate gets a 1&1 vector plus its three ways of producing 0.
    always_comb begin
        A = 2'b00;
        B = 2'b00;
        case (index)
            3'd0: begin A = 2'b10; B = 2'b10; end
            3'd1: begin A = 2'b00; B = 2'b10; end
            3'd2: begin A = 2'b10; B = 2'b00; end
            3'd3: begin A = 2'b00; B = 2'b00; end
            3'd4: begin A = 2'b01; B = 2'b01; end
            3'd5: begin A = 2'b00; B = 2'b01; end
            3'd6: begin A = 2'b01; B = 2'b00; end
            default: begin A = 2'b00; B = 2'b00; end
        endcase
        Y_EXP = A & B;
    end

endmodule

// File: rtl/and2x2_test_sequencer.sv
// Steps a dual AND gate through eight vectors, waits SETTLE cycles per vector, and reports
// PASS plus the first failing index. Outputs are registered from the next-state decode.
module and2x2_test_sequencer
    import gate_test_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [0:1] Y,
    output logic [0:1] A,
    output logic [0:1] B,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [2:0] FAIL_IDX
);

    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fail_q, fail_d;
    logic [IDX_W-1:0]   fidx_q, fidx_d;
    logic [0:1]         a_q, a_d;
    logic [0:1]         b_q, b_d;
    logic [0:1]         yexp_q, yexp_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [0:1]         rom_a, rom_b, rom_y;

    // Indexed by the next index so A/B are already valid in the first APPLY cycle.
    gate_vector_rom u_rom (
        .index (idx_d),
        .A     (rom_a),
        .B     (rom_b),
        .Y_EXP (rom_y)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
            fidx_q  <= '0;
            a_q     <= 2'b00;
            b_q     <= 2'b00;
            yexp_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            fidx_q  <= fidx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            yexp_q  <= yexp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        fidx_d  = fidx_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_APPLY;
                    idx_d   = '0;
                    fail_d  = 1'b0;
                    fidx_d  = '0;
                end
            end
            ST_APPLY: begin
                state_d = ST_WAIT;
                cnt_d   = SETTLE_CNT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Only the first mismatch of a run is recorded.
                if ((Y != yexp_q) && !fail_q) begin
                    fail_d = 1'b1;
                    fidx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_APPLY;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        a_d    = 2'b00;
        b_d    = 2'b00;
        yexp_d = yexp_q;
        busy_d = 1'b0;
        done_d = 1'b0;
        pass_d = pass_q;
        case (state_d)
            ST_APPLY, ST_WAIT, ST_CHECK: begin
                a_d    = rom_a;
                b_d    = rom_b;
                yexp_d = rom_y;
                busy_d = 1'b1;
            end
            ST_FINISH: begin
                done_d = 1'b1;
                pass_d = ~fail_d;
            end
            default: begin
            end
        endcase
        if ((state_q == ST_IDLE) && START) begin
            pass_d = 1'b0;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign FAIL_IDX = fidx_q;

endmodule

// File: tb/tb_and2x2_test_sequencer.sv
// Randomized fault/glitch runs against a table-driven model of the expected run outcome and timing.
module tb_and2x2_test_sequencer;

    localparam int S1   = 2;
    localparam int PER1 = S1 + 2;
    localparam int RUN1 = 8 * PER1;
    localparam int S2   = 1;
    localparam int PER2 = 8 * (S2 + 2) + 2;

    logic       clk = 1'b0;
    logic       rst, start, start2;
    logic [0:1] y, a, b, y2, a2, b2;
    logic       busy, done, pass, busy2, done2, pass2;
    logic [2:0] fidx, fidx2;
    logic [0:1] sa0, sa1, glitch_val;
    logic       glitch_on;

    int n_chk  = 0;
    int n_fail = 0;

    logic [0:1] tbl_a [8] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    logic [0:1] tbl_b [8] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};

    always #5 clk = ~clk;

    // Device under control: AND gates with optional stuck-at faults and out-of-window noise.
    assign y  = glitch_on ? glitch_val : (((a & b) & ~sa0) | sa1);
    assign y2 = a2 & b2;

    and2x2_test_sequencer #(.SETTLE(S1)) u_dut (
        .CLK(clk), .RST(rst), .START(start), .Y(y), .A(a), .B(b),
        .BUSY(busy), .DONE(done), .PASS(pass), .FAIL_IDX(fidx)
    );

    and2x2_test_sequencer #(.SETTLE(S2)) u_dut2 (
        .CLK(clk), .RST(rst), .START(start2), .Y(y2), .A(a2), .B(b2),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .FAIL_IDX(fidx2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_once(input logic [0:1] m0, input logic [0:1] m1, input bit noisy);
        int         c;
        int         v;
        int         ph;
        bit         exp_pass;
        int         exp_idx;
        logic [0:1] good, seen;
        sa0 = m0;
        sa1 = m1;
        exp_pass = 1'b1;
        exp_idx  = 0;
        for (int i = 0; i < 8; i++) begin
            good = tbl_a[i] & tbl_b[i];
            seen = (good & ~m0) | m1;
            if (exp_pass && (seen != good)) begin
                exp_pass = 1'b0;
                exp_idx  = i;
            end
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        check_eq("pass_cleared", pass, 0);
        while (!done && c <= RUN1 + 5) begin
            v  = (c - 1) / PER1;
            ph = (c - 1) % PER1;
            if (v < 8) begin
                check_eq("busy_run", busy, 1);
                check_eq("a_vec", a, tbl_a[v]);
                check_eq("b_vec", b, tbl_b[v]);
            end
            glitch_on  = noisy && (ph != PER1 - 1);
            glitch_val = 2'($urandom);
            if (noisy) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            c++;
        end
        glitch_on = 1'b0;
        start     = 1'b0;
        check_eq("done_cycle", c, RUN1 + 1);
        check_eq("pass", pass, exp_pass);
        check_eq("fail_idx", fidx, exp_idx);
        check_eq("busy_finish", busy, 0);
        check_eq("a_finish", a, 0);
        check_eq("b_finish", b, 0);
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        check_eq("busy_idle", busy, 0);
        check_eq("pass_hold", pass, exp_pass);
        check_eq("fidx_hold", fidx, exp_idx);
        @(negedge clk);
        check_eq("no_restart", busy, 0);
    endtask

    initial begin
        int cyc;
        int dones;
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        sa0 = 2'b00; sa1 = 2'b00; glitch_on = 1'b0; glitch_val = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_fidx", fidx, 0);
        check_eq("rst_a", a, 0);
        check_eq("rst_b", b, 0);

        // Reset wins over a simultaneous START.
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_eq("rst_vs_start", busy, 0);
        @(negedge clk);
        check_eq("rst_vs_start2", busy, 0);

        run_once(2'b00, 2'b00, 1'b0);
        run_once(2'b10, 2'b00, 1'b0);
        run_once(2'b00, 2'b01, 1'b0);
        run_once(2'b01, 2'b00, 1'b0);
        run_once(2'b00, 2'b00, 1'b1);
        for (int r = 0; r < 6; r++) begin
            logic [0:1] m0, m1;
            m0 = 2'($urandom);
            m1 = 2'($urandom) & ~m0;
            run_once(m0, m1, 1'b1);
        end

        // Mid-run reset aborts without a DONE pulse.
        sa0 = 2'b10;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_a", a, 0);
        check_eq("abort_b", b, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_pass", pass, 0);
        check_eq("abort_fidx", fidx, 0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("abort_no_done", dones, 0);
        run_once(2'b00, 2'b00, 1'b0);

        // START held high on the SETTLE=1 instance: back-to-back runs.
        start2 = 1'b1;
        cyc = 0;
        while (!done2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("hold_first_done", done2, 1);
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            @(negedge clk);
            cyc++;
            check_eq("hold_pulse_width", done2, 0);
            while (!done2 && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            check_eq("hold_period", cyc, PER2);
            check_eq("hold_pass", pass2, 1);
        end
        start2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
